register_file: RTL

REGISTER_FILE -- requirements
Module: register_file

---
 rtl/register_file_if.sv | 26 ++
 rtl/register_file.sv | 55 +++++
 2 files changed

// File: rtl/register_file_if.sv
// Write/read bus of the register file.
// master drives write and read addresses; slave returns read data.
interface register_file_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 3
);
  logic                  we;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [DATA_WIDTH-1:0] wdata;
  logic [ADDR_WIDTH-1:0] raddr_a;
  logic [DATA_WIDTH-1:0] rdata_a;
  logic [ADDR_WIDTH-1:0] raddr_b;
  logic [DATA_WIDTH-1:0] rdata_b;

  modport master (
    output we, waddr, wdata,
    output raddr_a, raddr_b,
    input  rdata_a, rdata_b
  );

  modport slave (
    input  we, waddr, wdata,
    input  raddr_a, raddr_b,
    output rdata_a, rdata_b
  );
endinterface

// File: rtl/register_file.sv
// 1W/2R register file, r0 hardwired to zero, sync active-high reset.
// Define REGISTER_FILE_BYPASS_EN to forward same-cycle write data to reads.
module register_file #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  register_file_if.slave   bus
);
  localparam int NREG = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs_q [NREG];
  logic [DATA_WIDTH-1:0] regs_d [NREG];
  logic                  wr_en;
  logic                  hit_a;
  logic                  hit_b;

  assign wr_en = !rst && bus.we && (bus.waddr != '0);

  always_comb begin
    regs_d = regs_q;
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs_d[i] = '0;
    end else if (wr_en) begin
      regs_d[bus.waddr] = bus.wdata;
    end
    regs_d[0] = '0;
  end

  always_ff @(posedge clk) begin
    regs_q <= regs_d;
  end

`ifdef REGISTER_FILE_BYPASS_EN
  assign hit_a = wr_en && (bus.waddr == bus.raddr_a);
  assign hit_b = wr_en && (bus.waddr == bus.raddr_b);
`else
  assign hit_a = 1'b0;
  assign hit_b = 1'b0;
`endif

  // r0 reads as zero even before the first reset
  always_comb begin
    bus.rdata_a = '0;
    if (bus.raddr_a != '0)
      bus.rdata_a = hit_a ? bus.wdata : regs_q[bus.raddr_a];
  end

  always_comb begin
    bus.rdata_b = '0;
    if (bus.raddr_b != '0)
      bus.rdata_b = hit_b ? bus.wdata : regs_q[bus.raddr_b];
  end
endmodule
